seq_detect_param: RTL and testbench
===================================

// Module: seq_detect_param
// PURPOSE
//   Runtime-programmable serial bit-pattern detector: next generation of the fixed Moore detector.
//   - Pattern length 1..MAX_LEN and pattern value loadable at run time.
//   - Overlapping or non-overlapping match mode; qualifies input with data_valid.
//   - Registered one-cycle detect pulse; sits on serial data paths (framing, sync words, commands).
// PARAMETERS
//   MAX_LEN         8         max pattern length in bits (2..32); history register width
//   DEFAULT_LEN     4         pattern length after reset (1..MAX_LEN)
//   DEFAULT_PATTERN 8'h0B     pattern after reset (LSBs used; 4'b1011 at DEFAULT_LEN=4)
//   DEFAULT_OVERLAP 1         overlap mode after reset (1=overlap, 0=non-overlap)
//   CNT_W           8         match counter width (only with SEQ_DETECT_COUNT_EN)
// PORTS
//   clock        in   1                     rising-edge clock
//   reset        in   1                     asynchronous, active-high reset
//   data_in      in   1                     serial input bit, sampled when data_valid=1
//   data_valid   in   1                     qualifies data_in; bit ignored when 0
//   cfg_load     in   1                     load cfg_* into config regs; clears detector state
//   cfg_pattern  in   MAX_LEN               new pattern; bit [len-1] = first bit received
//   cfg_len      in   $clog2(MAX_LEN+1)     new pattern length
//   cfg_overlap  in   1                     new overlap mode
//   cnt_clear    in   1                     synchronous clear of match_count
//   detect       out  1                     registered one-cycle match pulse
//   armed        out  1                     1 when fill >= active length (match possible next bit)
//   match_count  out  CNT_W                 saturating match count (SEQ_DETECT_COUNT_EN only)
// BEHAVIOUR
//   Reset (async, immediate):
//     - hist=0, fill=0, detect=0, armed=0, match_count=0
//     - pattern=DEFAULT_PATTERN, len=DEFAULT_LEN, overlap=DEFAULT_OVERLAP
//   Sampling (edge with data_valid=1, cfg_load=0):
//     - nhist = {hist[MAX_LEN-2:0], data_in}; nfill = min(fill+1, MAX_LEN)
//     - match = (nfill >= len) && (nhist[len-1:0] == pattern[len-1:0])
//     - hist <= nhist
//     - fill <= (match && !overlap) ? 0 : nfill
//   Output timing:
//     - detect <= match, so detect is high exactly one cycle starting at the edge that sampled the last pattern bit.
//     - detect is 0 on any edge with data_valid=0. No back-to-back detects in non-overlap mode unless len=1.
//     - armed = (fill >= len) registered-state decode; 0 during and after reset.
//   cfg_load (priority over sampling):
//     - pattern <= cfg_pattern, overlap <= cfg_overlap
//     - len <= clamp(cfg_len, 1, MAX_LEN): 0 -> 1, >MAX_LEN -> MAX_LEN
//     - hist <= 0, fill <= 0, detect <= 0; data_in ignored that cycle; match_count unchanged
//   Boundaries:
//     - fill saturates at MAX_LEN (never wraps).
//     - len=1 in overlap mode: detect high on every matching valid bit.
//     - reset mid-sequence: partial match discarded; the full pattern is needed again.
// CONFIGURATION
//   SEQ_DETECT_COUNT_EN defined:
//     - match_count and cnt_clear are present.
//     - match_count increments on each edge where match=1; saturates at 2^CNT_W-1.
//     - cnt_clear wins over a simultaneous match: result 0.
//   SEQ_DETECT_COUNT_EN undefined:
//     - match_count port and counter are absent; cnt_clear port is absent.
//     - Detector behaviour is otherwise identical.
// TESTING
//   T1 reset defaults (1011, overlap) -> stream 1,0,1,1,0,1,1 valid every cycle:
//      detect after the 4th and 7th bits, one cycle each; match_count=2.
//   T2 cfg_load pattern=1011, len=4, overlap=0 -> same stream: detect after the 4th bit only; count=1.
//   T3 data_valid low for 3 cycles between bits 2 and 3 of 1,0,1,1: still exactly one detect after the 4th valid bit.
//      detect=0 during the gap.
//   T4 stream 1,0,1 then reset pulse then 1: no detect; armed=0 after reset.
//      Then 0,1,1 -> one detect.
//   T5 cfg_load len=3 pattern=110 mid-stream (history 101): old history discarded.
//      1,1,0 -> detect; cfg_len=0 -> len=1; cfg_len=12 -> len=8.
//   T6 (COUNT_EN, CNT_W=2) 5 matches -> match_count=3 (saturated).
//      cnt_clear coincident with a match -> match_count=0.

Source files
------------

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector (length, value and overlap mode loadable).
// Optional saturating match counter enabled by defining SEQ_DETECT_COUNT_EN.
module seq_detect_param #(
  parameter int                 MAX_LEN         = 8,
  parameter int                 DEFAULT_LEN     = 4,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(8'h0B),
  parameter bit                 DEFAULT_OVERLAP = 1'b1,
  parameter int                 CNT_W           = 8,
  localparam int                LEN_W           = $clog2(MAX_LEN + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               data_in,
  input  logic               data_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
`ifdef SEQ_DETECT_COUNT_EN
  input  logic               cnt_clear,
`endif
  output logic               detect,
  output logic               armed
`ifdef SEQ_DETECT_COUNT_EN
  ,
  output logic [CNT_W-1:0]   match_count
`endif
);

  if (MAX_LEN < 2 || MAX_LEN > 32) begin : g_bad_max_len
    $error("MAX_LEN must be in 2..32");
  end
  if (DEFAULT_LEN < 1 || DEFAULT_LEN > MAX_LEN) begin : g_bad_default_len
    $error("DEFAULT_LEN must be in 1..MAX_LEN");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  // The oldest history bit is shifted out before it could ever be compared again,
  // so only MAX_LEN-1 bits are stored; the incoming bit completes the window.
  logic [MAX_LEN-2:0] hist;
  logic [MAX_LEN-1:0] nhist;
  logic [MAX_LEN-1:0] pattern;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   nfill;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   len_clamped;
  logic               overlap;
  logic               match;

  always_comb begin
    nhist = {hist, data_in};
    nfill = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
    mask  = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (LEN_W'(i) < len);
    match = data_valid && !cfg_load && (nfill >= len) &&
            (((nhist ^ pattern) & mask) == '0);
    if (cfg_len == '0)                    len_clamped = LEN_W'(1);
    else if (cfg_len > LEN_W'(MAX_LEN))   len_clamped = LEN_W'(MAX_LEN);
    else                                  len_clamped = cfg_len;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist    <= '0;
      fill    <= '0;
      detect  <= 1'b0;
      pattern <= DEFAULT_PATTERN;
      len     <= LEN_W'(DEFAULT_LEN);
      overlap <= DEFAULT_OVERLAP;
    end else if (cfg_load) begin
      pattern <= cfg_pattern;
      len     <= len_clamped;
      overlap <= cfg_overlap;
      hist    <= '0;
      fill    <= '0;
      detect  <= 1'b0;
    end else begin
      detect <= match;
      if (data_valid) begin
        hist <= nhist[MAX_LEN-2:0];
        fill <= (match && !overlap) ? '0 : nfill;
      end
    end
  end

  assign armed = (fill >= len);

`ifdef SEQ_DETECT_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                           match_count <= '0;
    else if (cnt_clear)                  match_count <= '0;
    else if (match && match_count != '1) match_count <= match_count + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param; counter checks need SEQ_DETECT_COUNT_EN.
module tb_seq_detect_param;

  logic       clock = 1'b0;
  logic       reset;
  logic       data_in;
  logic       data_valid;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       detect;
  logic       armed;
`ifdef SEQ_DETECT_COUNT_EN
  logic       cnt_clear;
  logic [1:0] match_count;
`endif

  int tests = 0;
  int fails = 0;

  seq_detect_param #(
    .MAX_LEN(8), .DEFAULT_LEN(4), .DEFAULT_PATTERN(8'h0B), .DEFAULT_OVERLAP(1'b1), .CNT_W(2)
  ) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
`ifdef SEQ_DETECT_COUNT_EN
    .cnt_clear(cnt_clear),
`endif
    .detect(detect), .armed(armed)
`ifdef SEQ_DETECT_COUNT_EN
    , .match_count(match_count)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  // Drive one cycle of input; returns 1 time unit after the sampling edge.
  task automatic step(input logic b, input logic v);
    data_in = b;
    data_valid = v;
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] l, input logic ov);
    cfg_load = 1'b1; cfg_pattern = pat; cfg_len = l; cfg_overlap = ov;
    step(1'b1, 1'b1);
    cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; data_in = 1'b0; data_valid = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
`ifdef SEQ_DETECT_COUNT_EN
    cnt_clear = 1'b0;
`endif
    #2;
    tests++; if (detect !== 1'b0) begin fails++; $display("FAIL reset_detect: got %b want 0", detect); end
    tests++; if (armed !== 1'b0) begin fails++; $display("FAIL reset_armed: got %b want 0", armed); end
`ifdef SEQ_DETECT_COUNT_EN
    tests++; if (match_count !== 2'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", match_count); end
`endif
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_overlap_default();
    logic [6:0] s, e;
    s = 7'b1011011; e = 7'b0001001;
    for (int i = 0; i < 7; i++) begin
      step(s[6-i], 1'b1);
      tests++;
      if (detect !== e[6-i]) begin fails++; $display("FAIL t1_detect[%0d]: got %b want %b", i, detect, e[6-i]); end
      if (i == 2) begin
        tests++; if (armed !== 1'b0) begin fails++; $display("FAIL t1_armed3: got %b want 0", armed); end
      end
      if (i == 3) begin
        tests++; if (armed !== 1'b1) begin fails++; $display("FAIL t1_armed4: got %b want 1", armed); end
      end
    end
`ifdef SEQ_DETECT_COUNT_EN
    tests++; if (match_count !== 2'd2) begin fails++; $display("FAIL t1_count: got %0d want 2", match_count); end
`endif
  endtask

  task automatic test_non_overlap();
    logic [6:0] s, e;
    s = 7'b1011011; e = 7'b0001000;
    load(8'h0B, 4'd4, 1'b0);
    tests++; if (detect !== 1'b0) begin fails++; $display("FAIL t2_load_detect: got %b want 0", detect); end
`ifdef SEQ_DETECT_COUNT_EN
    tests++; if (match_count !== 2'd2) begin fails++; $display("FAIL t2_count_kept: got %0d want 2", match_count); end
    cnt_clear = 1'b1;
    step(1'b0, 1'b0);
    cnt_clear = 1'b0;
`endif
    for (int i = 0; i < 7; i++) begin
      step(s[6-i], 1'b1);
      tests++;
      if (detect !== e[6-i]) begin fails++; $display("FAIL t2_detect[%0d]: got %b want %b", i, detect, e[6-i]); end
      if (i == 3) begin
        tests++; if (armed !== 1'b0) begin fails++; $display("FAIL t2_armed_after_match: got %b want 0", armed); end
      end
    end
`ifdef SEQ_DETECT_COUNT_EN
    tests++; if (match_count !== 2'd1) begin fails++; $display("FAIL t2_count: got %0d want 1", match_count); end
`endif
  endtask

  task automatic test_valid_gap();
    logic [6:0] b, v, e;
    b = 7'b1011111; v = 7'b1100011; e = 7'b0000001;
    load(8'h0B, 4'd4, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(b[6-i], v[6-i]);
      tests++;
      if (detect !== e[6-i]) begin fails++; $display("FAIL t3_detect[%0d]: got %b want %b", i, detect, e[6-i]); end
    end
    step(1'b1, 1'b0);
    tests++; if (detect !== 1'b0) begin fails++; $display("FAIL t3_pulse_end: got %b want 0", detect); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] s;
    logic [3:0] t, e;
    s = 3'b101; t = 4'b1011; e = 4'b0001;
    for (int i = 0; i < 3; i++) step(s[2-i], 1'b1);
    data_valid = 1'b0;
    reset = 1'b1;
    #2;
    tests++; if (armed !== 1'b0) begin fails++; $display("FAIL t4_armed_reset: got %b want 0", armed); end
    tests++; if (detect !== 1'b0) begin fails++; $display("FAIL t4_detect_reset: got %b want 0", detect); end
`ifdef SEQ_DETECT_COUNT_EN
    tests++; if (match_count !== 2'd0) begin fails++; $display("FAIL t4_count_reset: got %0d want 0", match_count); end
`endif
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(t[3-i], 1'b1);
      tests++;
      if (detect !== e[3-i]) begin fails++; $display("FAIL t4_detect[%0d]: got %b want %b", i, detect, e[3-i]); end
    end
  endtask

  task automatic test_reload_len();
    logic [2:0] s, p;
    logic [3:0] q, qe;
    logic [7:0] w;
    s = 3'b101; p = 3'b110; q = 4'b1101; qe = 4'b1101; w = 8'hA5;
    for (int i = 0; i < 3; i++) step(s[2-i], 1'b1);
    load(8'b0000_0110, 4'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(p[2-i], 1'b1);
      tests++;
      if (detect !== (i == 2)) begin fails++; $display("FAIL t5_len3_detect[%0d]: got %b want %b", i, detect, i == 2); end
      if (i == 0) begin
        tests++; if (armed !== 1'b0) begin fails++; $display("FAIL t5_history_cleared: armed got %b want 0", armed); end
      end
    end
    // cfg_len=0 clamps to a single-bit pattern
    load(8'h01, 4'd0, 1'b1);
    tests++; if (armed !== 1'b0) begin fails++; $display("FAIL t5_len1_armed_load: got %b want 0", armed); end
    for (int i = 0; i < 4; i++) begin
      step(q[3-i], 1'b1);
      tests++;
      if (detect !== qe[3-i]) begin fails++; $display("FAIL t5_len1_detect[%0d]: got %b want %b", i, detect, qe[3-i]); end
    end
    tests++; if (armed !== 1'b1) begin fails++; $display("FAIL t5_len1_armed: got %b want 1", armed); end
    // cfg_len=12 clamps to 8; 20 zeros exercise fill saturation
    load(8'hA5, 4'd12, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    tests++; if (armed !== 1'b1) begin fails++; $display("FAIL t5_fill_saturate: armed got %b want 1", armed); end
    for (int i = 0; i < 8; i++) begin
      step(w[7-i], 1'b1);
      tests++;
      if (detect !== (i == 7)) begin fails++; $display("FAIL t5_len8_detect[%0d]: got %b want %b", i, detect, i == 7); end
    end
  endtask

`ifdef SEQ_DETECT_COUNT_EN
  task automatic test_count_sat();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    load(8'h01, 4'd1, 1'b1);
    cnt_clear = 1'b1;
    step(1'b0, 1'b0);
    cnt_clear = 1'b0;
    tests++; if (match_count !== 2'd0) begin fails++; $display("FAIL t6_clear: got %0d want 0", match_count); end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1);
      tests++;
      if (match_count !== exp_cnt[i]) begin fails++; $display("FAIL t6_count[%0d]: got %0d want %0d", i, match_count, exp_cnt[i]); end
    end
    cnt_clear = 1'b1;
    step(1'b1, 1'b1);
    cnt_clear = 1'b0;
    tests++; if (detect !== 1'b1) begin fails++; $display("FAIL t6_clear_detect: got %b want 1", detect); end
    tests++; if (match_count !== 2'd0) begin fails++; $display("FAIL t6_clear_wins: got %0d want 0", match_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_overlap_default();
    test_non_overlap();
    test_valid_gap();
    test_reset_mid();
    test_reload_len();
`ifdef SEQ_DETECT_COUNT_EN
    test_count_sat();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
